// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Runs up to LAYER_N convolution layers back-to-back. The layers are taken from a
// writable descriptor table. For each layer the block:
//   - loads the layer geometry, addresses and padding onto registered config outputs;
//   - drives a START_LEN-cycle start pulse;
//   - waits for conv_done.
// Alongside, it streams CORE_N weight lanes (aw) from per-lane RAMs. The read
// pointer starts at the layer's aw base address and advances on each cout_valid.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   run, layer_num    start request (IDLE only) and number of layers to run
//   desc_*            descriptor table write port (dropped while busy)
//   aw_we/ch/waddr/wdata  aw RAM write port (accepted any time)
//   cout_valid        engine consumed the current weight set
//   conv_done         engine finished the current layer
//   row, col, dX_addr_rds, dY_addr_rds, dW_addr_rds, padding   registered layer config
//   start             start pulse to the engine
//   aw                lane k at [k*INTWIDTH +: INTWIDTH]
//   busy, done, layer_idx, err   sequencing status; err is sticky until reset
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for run; config outputs hold their last values
// LOAD   | copy descriptor[layer_idx] to config regs, reload aw pointer
// START  | start high for START_LEN cycles, remembers an early conv_done
// WAIT   | waiting for conv_done from the engine
// NEXT   | advance to the next layer or finish
// DONE   | one-cycle done pulse
module conv_layer_sequencer #(
   parameter int CORE_N    = 4,
   parameter int INTWIDTH  = 16,
   parameter int VAW       = 16,
   parameter int MAW       = 16,
   parameter int AW_AW     = 10,
   parameter int LAYER_N   = 4,
   parameter int LIW       = 2,
   parameter int START_LEN = 4
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          run,
   input  logic [LIW:0]                                  layer_num,
   input  logic                                          desc_we,
   input  logic [LIW-1:0]                                desc_idx,
   input  logic [15:0]                                   desc_row,
   input  logic [15:0]                                   desc_col,
   input  logic                                          desc_pad,
   input  logic [VAW-1:0]                                desc_dx,
   input  logic [VAW-1:0]                                desc_dy,
   input  logic [MAW-1:0]                                desc_dw,
   input  logic [AW_AW-1:0]                              desc_awb,
   input  logic                                          aw_we,
   input  logic [((CORE_N > 1) ? $clog2(CORE_N) : 1)-1:0] aw_ch,
   input  logic [AW_AW-1:0]                              aw_waddr,
   input  logic [INTWIDTH-1:0]                           aw_wdata,
   input  logic                                          cout_valid,
   input  logic                                          conv_done,
   output logic [15:0]                                   row,
   output logic [15:0]                                   col,
   output logic [VAW-1:0]                                dX_addr_rds,
   output logic [VAW-1:0]                                dY_addr_rds,
   output logic [MAW-1:0]                                dW_addr_rds,
   output logic                                          padding,
   output logic                                          start,
   output logic [CORE_N*INTWIDTH-1:0]                    aw,
   output logic                                          busy,
   output logic                                          done,
   output logic [LIW-1:0]                                layer_idx,
   output logic                                          err
);

   localparam int SCW = (START_LEN > 1) ? $clog2(START_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [SCW-1:0]           start_cnt_q, start_cnt_d;
   logic                     done_seen_q, done_seen_d;
   logic [LIW:0]             num_q, num_d;
   logic [LIW-1:0]           layer_idx_q, layer_idx_d;
   logic [AW_AW-1:0]         cout_cnt_q, cout_cnt_d;
   logic                     err_q, err_d;
   logic [15:0]              row_q, row_d, col_q, col_d;
   logic [VAW-1:0]           dx_q, dx_d, dy_q, dy_d;
   logic [MAW-1:0]           dw_q, dw_d;
   logic                     pad_q, pad_d;
   logic [CORE_N*INTWIDTH-1:0] aw_q, aw_d;

   logic [15:0]              tbl_row [LAYER_N];
   logic [15:0]              tbl_col [LAYER_N];
   logic                     tbl_pad [LAYER_N];
   logic [VAW-1:0]           tbl_dx  [LAYER_N];
   logic [VAW-1:0]           tbl_dy  [LAYER_N];
   logic [MAW-1:0]           tbl_dw  [LAYER_N];
   logic [AW_AW-1:0]         tbl_awb [LAYER_N];

   logic [INTWIDTH-1:0]      aw_ram [CORE_N][2**AW_AW];

   // Outputs are plain decodes of registered state, so reset clears them at once.
   assign busy        = (state_q == S_LOAD) || (state_q == S_START) ||
                        (state_q == S_WAIT) || (state_q == S_NEXT);
   assign start       = (state_q == S_START);
   assign done        = (state_q == S_DONE);
   assign layer_idx   = layer_idx_q;
   assign err         = err_q;
   assign row         = row_q;
   assign col         = col_q;
   assign dX_addr_rds = dx_q;
   assign dY_addr_rds = dy_q;
   assign dW_addr_rds = dw_q;
   assign padding     = pad_q;
   assign aw          = aw_q;

   // Descriptor table: no reset; writes are dropped while a sequence is in flight.
   always_ff @(posedge clk) begin
      if (desc_we && !busy && (int'(desc_idx) < LAYER_N)) begin
         tbl_row[desc_idx] <= desc_row;
         tbl_col[desc_idx] <= desc_col;
         tbl_pad[desc_idx] <= desc_pad;
         tbl_dx[desc_idx]  <= desc_dx;
         tbl_dy[desc_idx]  <= desc_dy;
         tbl_dw[desc_idx]  <= desc_dw;
         tbl_awb[desc_idx] <= desc_awb;
      end
   end

   // When a write and a read hit the same address in one cycle, the read returns the old word.
   always_ff @(posedge clk) begin
      if (aw_we && (int'(aw_ch) < CORE_N)) begin
         aw_ram[aw_ch][aw_waddr] <= aw_wdata;
      end
   end

   for (genvar g = 0; g < CORE_N; g++) begin : g_aw_rd
      assign aw_d[g*INTWIDTH +: INTWIDTH] = aw_ram[g][cout_cnt_q];
   end

   always_comb begin
      state_d     = state_q;
      start_cnt_d = start_cnt_q;
      done_seen_d = done_seen_q;
      num_d       = num_q;
      layer_idx_d = layer_idx_q;
      cout_cnt_d  = cout_cnt_q;
      err_d       = err_q;
      row_d       = row_q;
      col_d       = col_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      dw_d        = dw_q;
      pad_d       = pad_q;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               if (layer_num == '0) begin
                  state_d = S_DONE;
               end else if (int'(layer_num) > LAYER_N) begin
                  err_d = 1'b1;
               end else begin
                  num_d       = layer_num;
                  layer_idx_d = '0;
                  state_d     = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            row_d       = tbl_row[layer_idx_q];
            col_d       = tbl_col[layer_idx_q];
            pad_d       = tbl_pad[layer_idx_q];
            dx_d        = tbl_dx[layer_idx_q];
            dy_d        = tbl_dy[layer_idx_q];
            dw_d        = tbl_dw[layer_idx_q];
            cout_cnt_d  = tbl_awb[layer_idx_q];
            start_cnt_d = SCW'(START_LEN - 1);
            done_seen_d = 1'b0;
            state_d     = S_START;
         end
         S_START: begin
            // A conv_done that arrives while start is still high is remembered, so the
            // layer skips WAIT.
            if (conv_done) done_seen_d = 1'b1;
            if (start_cnt_q == '0) begin
               state_d = (done_seen_q || conv_done) ? S_NEXT : S_WAIT;
            end else begin
               start_cnt_d = start_cnt_q - SCW'(1);
            end
         end
         S_WAIT: begin
            if (conv_done) state_d = S_NEXT;
         end
         S_NEXT: begin
            if ({1'b0, layer_idx_q} == (num_q - (LIW+1)'(1))) begin
               state_d = S_DONE;
            end else begin
               layer_idx_d = layer_idx_q + LIW'(1);
               state_d     = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The pointer only moves while the engine owns the layer; elsewhere a stray
      // cout_valid is flagged instead.
      if (cout_valid) begin
         if ((state_q == S_START) || (state_q == S_WAIT)) begin
            cout_cnt_d = cout_cnt_q + AW_AW'(1);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         start_cnt_q <= '0;
         done_seen_q <= 1'b0;
         num_q       <= '0;
         layer_idx_q <= '0;
         cout_cnt_q  <= '0;
         err_q       <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         dw_q        <= '0;
         pad_q       <= 1'b0;
         aw_q        <= '0;
      end else begin
         state_q     <= state_d;
         start_cnt_q <= start_cnt_d;
         done_seen_q <= done_seen_d;
         num_q       <= num_d;
         layer_idx_q <= layer_idx_d;
         cout_cnt_q  <= cout_cnt_d;
         err_q       <= err_d;
         row_q       <= row_d;
         col_q       <= col_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         dw_q        <= dw_d;
         pad_q       <= pad_d;
         aw_q        <= aw_d;
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
module tb_conv_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [2:0]  layer_num = '0;
   logic        desc_we = 1'b0;
   logic [1:0]  desc_idx = '0;
   logic [15:0] desc_row = '0, desc_col = '0;
   logic        desc_pad = 1'b0;
   logic [15:0] desc_dx = '0, desc_dy = '0, desc_dw = '0;
   logic [9:0]  desc_awb = '0;
   logic        aw_we = 1'b0;
   logic [1:0]  aw_ch = '0;
   logic [9:0]  aw_waddr = '0;
   logic [15:0] aw_wdata = '0;
   logic        cout_valid = 1'b0;
   logic        conv_done = 1'b0;
   logic [15:0] row, col, dX_addr_rds, dY_addr_rds, dW_addr_rds;
   logic        padding, start, busy, done, err;
   logic [63:0] aw;
   logic [1:0]  layer_idx;

   int n_cmp = 0;
   int n_err = 0;

   conv_layer_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .layer_num(layer_num),
      .desc_we(desc_we), .desc_idx(desc_idx), .desc_row(desc_row), .desc_col(desc_col),
      .desc_pad(desc_pad), .desc_dx(desc_dx), .desc_dy(desc_dy), .desc_dw(desc_dw),
      .desc_awb(desc_awb), .aw_we(aw_we), .aw_ch(aw_ch), .aw_waddr(aw_waddr),
      .aw_wdata(aw_wdata), .cout_valid(cout_valid), .conv_done(conv_done),
      .row(row), .col(col), .dX_addr_rds(dX_addr_rds), .dY_addr_rds(dY_addr_rds),
      .dW_addr_rds(dW_addr_rds), .padding(padding), .start(start), .aw(aw),
      .busy(busy), .done(done), .layer_idx(layer_idx), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_desc(input logic [1:0] idx, input logic [15:0] r, input logic [15:0] c,
                             input logic p, input logic [15:0] dx, input logic [15:0] dy,
                             input logic [15:0] dw, input logic [9:0] awb);
      desc_we = 1'b1; desc_idx = idx; desc_row = r; desc_col = c; desc_pad = p;
      desc_dx = dx; desc_dy = dy; desc_dw = dw; desc_awb = awb;
      tick();
      desc_we = 1'b0;
   endtask

   task automatic write_aw(input logic [1:0] ch, input logic [9:0] addr, input logic [15:0] d);
      aw_we = 1'b1; aw_ch = ch; aw_waddr = addr; aw_wdata = d;
      tick();
      aw_we = 1'b0;
   endtask

   task automatic pulse_run(input logic [2:0] n);
      run = 1'b1; layer_num = n;
      tick();
      run = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if ({row, col, padding} !== 33'd0) begin n_err++;
         $display("FAIL reset_cfg: row=%0d col=%0d pad=%0b need 0", row, col, padding); end
      n_cmp++; if ({start, busy, done, err, layer_idx} !== 6'd0) begin n_err++;
         $display("FAIL reset_ctrl: start=%0b busy=%0b done=%0b err=%0b idx=%0d need 0",
                  start, busy, done, err, layer_idx); end
      n_cmp++; if (aw !== 64'd0) begin n_err++;
         $display("FAIL reset_aw: aw=%h need 0", aw); end
      n_cmp++; if ({dX_addr_rds, dY_addr_rds, dW_addr_rds} !== 48'd0) begin n_err++;
         $display("FAIL reset_addr: got %h need 0", {dX_addr_rds, dY_addr_rds, dW_addr_rds}); end
      tick(2);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_layer();
      int scnt;
      write_desc(2'd0, 16'd28, 16'd28, 1'b1, 16'd0, 16'd0, 16'd0, 10'd0);
      pulse_run(3'd1);
      n_cmp++; if (busy !== 1'b1 || start !== 1'b0) begin n_err++;
         $display("FAIL single_load: busy=%0b start=%0b need 1/0", busy, start); end
      tick();
      n_cmp++; if (row !== 16'd28 || col !== 16'd28 || padding !== 1'b1) begin n_err++;
         $display("FAIL single_cfg: row=%0d col=%0d pad=%0b need 28/28/1", row, col, padding); end
      scnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (start) scnt++;
         tick();
      end
      n_cmp++; if (scnt !== 4) begin n_err++;
         $display("FAIL single_start_len: got %0d cycles need 4", scnt); end
      tick(4);
      n_cmp++; if (busy !== 1'b1) begin n_err++;
         $display("FAIL single_busy_wait: busy=%0b need 1", busy); end
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_err++;
         $display("FAIL single_done_early: done=%0b need 0", done); end
      tick();
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++;
         $display("FAIL single_done: done=%0b busy=%0b need 1/0", done, busy); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++;
         $display("FAIL single_done_width: done=%0b need 0", done); end
   endtask

   task automatic test_aw_stream();
      for (int i = 0; i < 4; i++) begin
         write_aw(2'd0, 10'(i), 16'(i + 1));
         write_aw(2'd3, 10'(i), 16'(16'h10 + i));
      end
      pulse_run(3'd1);
      tick(7);
      n_cmp++; if (aw[15:0] !== 16'd1 || aw[63:48] !== 16'h10) begin n_err++;
         $display("FAIL aw_base: lane0=%h lane3=%h need 0001/0010", aw[15:0], aw[63:48]); end
      for (int p = 1; p <= 3; p++) begin
         cout_valid = 1'b1;
         tick();
         cout_valid = 1'b0;
         tick();
         n_cmp++; if (aw[15:0] !== 16'(p + 1) || aw[63:48] !== 16'(16'h10 + p)) begin n_err++;
            $display("FAIL aw_step%0d: lane0=%h lane3=%h need %h/%h", p, aw[15:0], aw[63:48],
                     16'(p + 1), 16'(16'h10 + p)); end
      end
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      tick(3);
      // pointer rests at 3; overwrite that word and expect the old value first
      write_aw(2'd0, 10'd3, 16'h0055);
      n_cmp++; if (aw[15:0] !== 16'd4) begin n_err++;
         $display("FAIL aw_rdw_old: lane0=%h need 0004", aw[15:0]); end
      tick();
      n_cmp++; if (aw[15:0] !== 16'h0055) begin n_err++;
         $display("FAIL aw_rdw_new: lane0=%h need 0055", aw[15:0]); end
      n_cmp++; if (err !== 1'b0) begin n_err++;
         $display("FAIL aw_err: err=%0b need 0", err); end
   endtask

   task automatic test_multi_layer();
      int scnt;
      logic [15:0] exp_aw [3];
      exp_aw[0] = 16'hA000; exp_aw[1] = 16'hA100; exp_aw[2] = 16'hA3FF;
      write_desc(2'd0, 16'd10, 16'd20, 1'b0, 16'd0, 16'd0, 16'd0, 10'd0);
      write_desc(2'd1, 16'd11, 16'd21, 1'b1, 16'd0, 16'd0, 16'd0, 10'd100);
      write_desc(2'd2, 16'd12, 16'd22, 1'b0, 16'd0, 16'd0, 16'd0, 10'd1023);
      write_aw(2'd0, 10'd0, 16'hA000);
      write_aw(2'd0, 10'd100, 16'hA100);
      write_aw(2'd0, 10'd1023, 16'hA3FF);
      pulse_run(3'd3);
      for (int l = 0; l < 3; l++) begin
         n_cmp++; if (layer_idx !== 2'(l) || busy !== 1'b1) begin n_err++;
            $display("FAIL multi_idx%0d: idx=%0d busy=%0b need %0d/1", l, layer_idx, busy, l); end
         tick();
         n_cmp++; if (row !== 16'(10 + l) || col !== 16'(20 + l)) begin n_err++;
            $display("FAIL multi_cfg%0d: row=%0d col=%0d need %0d/%0d", l, row, col, 10 + l, 20 + l); end
         scnt = 0;
         for (int i = 0; i < 6; i++) begin
            if (start) scnt++;
            tick();
         end
         n_cmp++; if (scnt !== 4) begin n_err++;
            $display("FAIL multi_start%0d: got %0d cycles need 4", l, scnt); end
         n_cmp++; if (aw[15:0] !== exp_aw[l]) begin n_err++;
            $display("FAIL multi_awb%0d: lane0=%h need %h", l, aw[15:0], exp_aw[l]); end
         if (l == 2) begin
            cout_valid = 1'b1;
            tick();
            cout_valid = 1'b0;
            tick();
            n_cmp++; if (aw[15:0] !== 16'hA000) begin n_err++;
               $display("FAIL multi_wrap: lane0=%h need a000", aw[15:0]); end
         end
         conv_done = 1'b1;
         tick();
         conv_done = 1'b0;
         n_cmp++; if (done !== 1'b0) begin n_err++;
            $display("FAIL multi_next%0d: done=%0b need 0", l, done); end
         tick();
      end
      n_cmp++; if (done !== 1'b1) begin n_err++;
         $display("FAIL multi_done: done=%0b need 1", done); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++;
         $display("FAIL multi_idle: done=%0b busy=%0b need 0/0", done, busy); end
   endtask

   task automatic test_zero_and_overflow();
      int dcnt, scnt;
      dcnt = 0; scnt = 0;
      pulse_run(3'd0);
      for (int i = 0; i < 4; i++) begin
         if (done) dcnt++;
         if (start) scnt++;
         tick();
      end
      n_cmp++; if (dcnt !== 1 || scnt !== 0) begin n_err++;
         $display("FAIL zero_layers: done cycles=%0d start cycles=%0d need 1/0", dcnt, scnt); end
      n_cmp++; if (err !== 1'b0) begin n_err++;
         $display("FAIL zero_err: err=%0b need 0", err); end
      pulse_run(3'd5);
      n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++;
         $display("FAIL overflow: err=%0b busy=%0b need 1/0", err, busy); end
      tick();
      n_cmp++; if (busy !== 1'b0 || start !== 1'b0 || done !== 1'b0) begin n_err++;
         $display("FAIL overflow_idle: busy=%0b start=%0b done=%0b need 0", busy, start, done); end
   endtask

   task automatic test_busy_ignore();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (err !== 1'b0) begin n_err++;
         $display("FAIL busy_err_clr: err=%0b need 0", err); end
      write_desc(2'd0, 16'h40, 16'h41, 1'b0, 16'h1111, 16'h2222, 16'h3333, 10'd0);
      pulse_run(3'd1);
      tick(7);
      n_cmp++; if (dX_addr_rds !== 16'h1111 || dY_addr_rds !== 16'h2222 || dW_addr_rds !== 16'h3333) begin n_err++;
         $display("FAIL busy_addr: dx=%h dy=%h dw=%h need 1111/2222/3333", dX_addr_rds, dY_addr_rds, dW_addr_rds); end
      run = 1'b1; layer_num = 3'd1;
      desc_we = 1'b1; desc_idx = 2'd0; desc_row = 16'h99; desc_col = 16'h98; desc_pad = 1'b1;
      tick();
      run = 1'b0; desc_we = 1'b0;
      tick();
      n_cmp++; if (start !== 1'b0 || busy !== 1'b1) begin n_err++;
         $display("FAIL busy_run_ignored: start=%0b busy=%0b need 0/1", start, busy); end
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      tick();
      n_cmp++; if (done !== 1'b1) begin n_err++;
         $display("FAIL busy_done: done=%0b need 1", done); end
      tick(2);
      pulse_run(3'd1);
      tick();
      n_cmp++; if (row !== 16'h40 || col !== 16'h41 || padding !== 1'b0) begin n_err++;
         $display("FAIL busy_desc_kept: row=%h col=%h pad=%0b need 0040/0041/0", row, col, padding); end
      tick(6);
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      tick(3);
      n_cmp++; if (aw[15:0] !== 16'hA000 || err !== 1'b0) begin n_err++;
         $display("FAIL idle_pre: lane0=%h err=%0b need a000/0", aw[15:0], err); end
      cout_valid = 1'b1;
      tick();
      cout_valid = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_err++;
         $display("FAIL idle_cout_err: err=%0b need 1", err); end
      tick(2);
      n_cmp++; if (aw[15:0] !== 16'hA000) begin n_err++;
         $display("FAIL idle_cout_cnt: lane0=%h need a000", aw[15:0]); end
   endtask

   task automatic test_reset_mid();
      int scnt;
      pulse_run(3'd1);
      tick();
      n_cmp++; if (start !== 1'b1) begin n_err++;
         $display("FAIL mid_start: start=%0b need 1", start); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (start !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_err++;
         $display("FAIL mid_async: start=%0b busy=%0b err=%0b need 0/0/0", start, busy, err); end
      #1;
      rst_n = 1'b1;
      tick();
      pulse_run(3'd1);
      n_cmp++; if (busy !== 1'b1 || layer_idx !== 2'd0) begin n_err++;
         $display("FAIL fresh_load: busy=%0b idx=%0d need 1/0", busy, layer_idx); end
      tick();
      n_cmp++; if (row !== 16'h40 || start !== 1'b1) begin n_err++;
         $display("FAIL fresh_cfg: row=%h start=%0b need 0040/1", row, start); end
      scnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (start) scnt++;
         tick();
      end
      n_cmp++; if (scnt !== 4) begin n_err++;
         $display("FAIL fresh_start_len: got %0d need 4", scnt); end
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      tick();
      n_cmp++; if (done !== 1'b1) begin n_err++;
         $display("FAIL fresh_done: done=%0b need 1", done); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_layer();
      test_aw_stream();
      test_multi_layer();
      test_zero_and_overflow();
      test_busy_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
